// File: rtl/nrd_pkg.sv
// Shared types and constants for the sequential non-restoring divider scheduler.
package nrd_pkg;

   localparam int unsigned W = 4;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   typedef enum logic [1:0] {IDLE, ITER, FIX, RESP} state_e;

endpackage

// File: rtl/nrd_div_sched_if.sv
// Request/response bundle between two requesters, one consumer and the divider scheduler.
interface nrd_div_sched_if #(
   parameter int unsigned W = nrd_pkg::W
);

   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_x;
   logic [2*W-1:0] req_y;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [W-1:0]   rsp_q;
   logic [W-1:0]   rsp_r;
   logic           rsp_dbz;
   logic           busy;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, busy
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, busy
   );

endinterface

// File: rtl/nrd_addsub.sv
// (W+1)-bit two's-complement adder/subtractor; mode 1 subtracts b from a.
module nrd_addsub #(
   parameter int unsigned W = 4
) (
   input  logic [W:0] a_i,
   input  logic [W:0] b_i,
   input  logic       mode_i,
   output logic [W:0] sum_o
);

   logic [W:0] b_x;

   assign b_x   = b_i ^ {(W+1){mode_i}};
   assign sum_o = a_i + b_x + {{W{1'b0}}, mode_i};

endmodule

// File: rtl/nrd_div_sched.sv
// Round-robin scheduler for two requesters sharing one iterative non-restoring divider.
module nrd_div_sched #(
   parameter int unsigned W = nrd_pkg::W
) (
   input logic            clk,
   input logic            rst_n,
   nrd_div_sched_if.slave bus
);

   import nrd_pkg::*;

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   state_e        state_q, state_d;
   logic [W:0]    a_q, a_d;
   logic [W:0]    d_q, d_d;
   logic [W-1:0]  q_q, q_d;
   logic          id_q, id_d;
   logic          dbz_q, dbz_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          grant;
   logic          accept;
   logic [W-1:0]  x_sel;
   logic [W-1:0]  y_sel;
   logic [W:0]    as_a;
   logic [W:0]    as_sum;
   logic          as_mode;

   // Tie goes to whoever did not win last; a lone request always wins.
   assign grant  = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
   assign accept = (state_q == IDLE) && (|bus.req_valid);
   assign x_sel  = grant ? bus.req_x[2*W-1:W] : bus.req_x[W-1:0];
   assign y_sel  = grant ? bus.req_y[2*W-1:W] : bus.req_y[W-1:0];

   nrd_addsub #(
      .W(W)
   ) u_addsub (
      .a_i   (as_a),
      .b_i   (d_q),
      .mode_i(as_mode),
      .sum_o (as_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         id_q    <= 1'b0;
         dbz_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         q_q     <= q_d;
         id_q    <= id_d;
         dbz_q   <= dbz_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      q_d     = q_q;
      id_d    = id_q;
      dbz_d   = dbz_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               d_d    = {1'b0, y_sel};
               id_d   = grant;
               last_d = grant;
               cnt_d  = '0;
               // Zero divisor skips the datapath and reports all-ones quotient.
               if (y_sel == '0) begin
                  q_d     = '1;
                  a_d     = {1'b0, x_sel};
                  dbz_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  q_d     = x_sel;
                  a_d     = '0;
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            a_d    = as_sum;
            q_d    = q_q << 1;
            q_d[0] = ~as_sum[W];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (a_q[W]) begin
               a_d = as_sum;
            end
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               dbz_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if ((state_q == IDLE) && rst_n) begin
         bus.req_ready[grant] = bus.req_valid[grant];
      end
      bus.busy = (state_q != IDLE);

      // ITER feeds the shifted {A,Q} top bits; FIX reuses the unit for the restore add.
      as_a    = a_q;
      as_mode = ADD;
      if (state_q == ITER) begin
         as_a    = {a_q[W-1:0], q_q[W-1]};
         as_mode = a_q[W] ? ADD : SUB;
      end

      bus.rsp_valid = (state_q == RESP);
      bus.rsp_q     = q_q;
      bus.rsp_r     = a_q[W-1:0];
      bus.rsp_id    = id_q;
      bus.rsp_dbz   = dbz_q;
   end

endmodule

// File: tb/tb_nrd_div_sched.sv
// Randomized self-checking bench for nrd_div_sched against an arithmetic divide model.
module tb_nrd_div_sched;

   localparam int unsigned TW = 4;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   nrd_div_sched_if #(.W(TW)) bus ();

   nrd_div_sched #(
      .W(TW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void ref_div(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                   output logic [TW-1:0] q, output logic [TW-1:0] r,
                                   output logic z, output int lat);
      if (y == 0) begin
         q = '1; r = x; z = 1'b1; lat = 1;
      end else begin
         q = x / y; r = x % y; z = 1'b0; lat = TW + 2;
      end
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic send(input int i, input logic [TW-1:0] x, input logic [TW-1:0] y,
                       output int acc, output bit ok);
      bus.req_x[i*TW +: TW] = x;
      bus.req_y[i*TW +: TW] = y;
      bus.req_valid[i] = 1'b1;
      ok  = 1'b0;
      acc = 0;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (bus.req_ready[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      acc = cyc;
      @(negedge clk);
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (bus.rsp_valid) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (bus.req_ready !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready);
      end
      checks++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL reset_valid_busy: got %b want 00", {bus.rsp_valid, bus.busy});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz} !== '0) begin
         errors++; $display("FAIL reset_rsp: got q=%0d r=%0d id=%0d dbz=%0d want all 0",
                            bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz);
      end
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int i, acc, at, el;
      logic [TW-1:0] x, y, eq, er;
      logic ez;
      bit ok;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         if (k == 0) begin
            i = 0; x = 13; y = 3;
         end else if (k == 1) begin
            i = 1; x = 2; y = 9;
         end else if (k == 2) begin
            i = 1; x = 15; y = 1;
         end else begin
            i = int'($urandom_range(1, 0));
            x = TW'($urandom_range(15, 0));
            y = TW'($urandom_range(15, 0));
         end
         ref_div(x, y, eq, er, ez, el);
         send(i, x, y, acc, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL single_accept: got no req_ready want accept (k=%0d)", k);
         end
         wait_rsp(at, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL single_rsp_timeout: got no rsp_valid want response");
         end else begin
            checks++;
            if (at - acc !== el) begin
               errors++; $display("FAIL single_latency: got %0d want %0d (x=%0d y=%0d)",
                                  at - acc, el, x, y);
            end
            checks++;
            if ({bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz} !== {eq, er, 1'(i), ez}) begin
               errors++;
               $display("FAIL single_result: got q=%0d r=%0d id=%0d dbz=%0d want q=%0d r=%0d id=%0d dbz=%0d",
                        bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz, eq, er, i, ez);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_dbz();
      int acc, at;
      bit ok;
      bus.rsp_ready = 1'b1;
      send(0, 4'd7, 4'd0, acc, ok);
      wait_rsp(at, ok);
      checks++;
      if (!ok || (at - acc !== 1)) begin
         errors++; $display("FAIL dbz_latency: got %0d (seen=%0d) want 1", at - acc, ok);
      end
      checks++;
      if ({bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz} !== {4'd15, 4'd7, 1'b0, 1'b1}) begin
         errors++; $display("FAIL dbz_result: got q=%0d r=%0d id=%0d dbz=%0d want 15 7 0 1",
                            bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_dbz} !== 2'b00) begin
         errors++; $display("FAIL dbz_clear: got valid/dbz=%b want 00", {bus.rsp_valid, bus.rsp_dbz});
      end
   endtask

   task automatic test_alternate();
      logic [TW-1:0] cur_x[2];
      logic [TW-1:0] cur_y[2];
      logic [TW-1:0] ex_q[$];
      logic [TW-1:0] ex_r[$];
      logic          ex_id[$];
      logic [TW-1:0] eq, er;
      logic          ez;
      bit            reload[2];
      int            last_g, exp_g, n_rsp, budget, last_acc, last_y, el;
      bit            have_acc;
      apply_reset();
      bus.rsp_ready = 1'b1;
      last_g   = 1;
      n_rsp    = 0;
      budget   = 0;
      have_acc = 1'b0;
      last_acc = 0;
      last_y   = 0;
      reload[0] = 1'b1;
      reload[1] = 1'b1;
      while (n_rsp < 8 && budget < 400) begin
         for (int i = 0; i < 2; i++) begin
            if (reload[i]) begin
               cur_x[i] = TW'($urandom_range(15, 0));
               cur_y[i] = TW'($urandom_range(15, 0));
               bus.req_x[i*TW +: TW] = cur_x[i];
               bus.req_y[i*TW +: TW] = cur_y[i];
               reload[i] = 1'b0;
            end
         end
         bus.req_valid = 2'b11;
         #1;
         if (bus.rsp_valid) begin
            checks++;
            if (ex_q.size() == 0) begin
               errors++; $display("FAIL alt_unexpected_rsp: got response id=%0d want none", bus.rsp_id);
            end else begin
               if ({bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {ex_q[0], ex_r[0], ex_id[0]}) begin
                  errors++;
                  $display("FAIL alt_result: got q=%0d r=%0d id=%0d want q=%0d r=%0d id=%0d",
                           bus.rsp_q, bus.rsp_r, bus.rsp_id, ex_q[0], ex_r[0], ex_id[0]);
               end
               void'(ex_q.pop_front());
               void'(ex_r.pop_front());
               void'(ex_id.pop_front());
            end
            n_rsp++;
         end
         if (bus.req_ready != 2'b00) begin
            exp_g = 1 - last_g;
            checks++;
            if (bus.req_ready !== 2'(1 << exp_g)) begin
               errors++; $display("FAIL alt_grant: got %b want %b", bus.req_ready, 2'(1 << exp_g));
            end
            if (have_acc) begin
               checks++;
               if (cyc - last_acc !== ((last_y == 0) ? 2 : TW + 3)) begin
                  errors++; $display("FAIL alt_period: got %0d want %0d", cyc - last_acc,
                                     (last_y == 0) ? 2 : TW + 3);
               end
            end
            ref_div(cur_x[exp_g], cur_y[exp_g], eq, er, ez, el);
            ex_q.push_back(eq);
            ex_r.push_back(er);
            ex_id.push_back(1'(exp_g));
            last_g   = exp_g;
            reload[exp_g] = 1'b1;
            last_acc = cyc;
            last_y   = int'(cur_y[exp_g]);
            have_acc = 1'b1;
         end
         @(negedge clk);
         budget++;
      end
      checks++;
      if (n_rsp < 8) begin
         errors++; $display("FAIL alt_timeout: got %0d responses want 8", n_rsp);
      end
      bus.req_valid = 2'b00;
      apply_reset();
   endtask

   task automatic test_backpressure();
      int acc, at;
      bit ok;
      bus.rsp_ready = 1'b0;
      send(1, 4'd11, 4'd4, acc, ok);
      wait_rsp(at, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid want response");
      end
      bus.req_x[TW-1:0] = 4'd5;
      bus.req_y[TW-1:0] = 4'd2;
      bus.req_valid[0]  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {1'b1, 4'd2, 4'd3, 1'b1}) begin
            errors++; $display("FAIL bp_hold: got v=%0d q=%0d r=%0d id=%0d want 1 2 3 1",
                               bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_id);
         end
         checks++;
         if (bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL bp_ready_low: got %b want 00", bus.req_ready);
         end
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin
         errors++; $display("FAIL bp_handshake_ready: got %b want 00", bus.req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 3'b001) begin
         errors++; $display("FAIL bp_next_accept: got valid=%0d ready=%b want 0 01",
                            bus.rsp_valid, bus.req_ready);
      end
      acc = cyc;
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      wait_rsp(at, ok);
      checks++;
      if (!ok || (at - acc !== TW + 2) ||
          ({bus.rsp_q, bus.rsp_r, bus.rsp_id} !== {4'd2, 4'd1, 1'b0})) begin
         errors++; $display("FAIL bp_followup: got lat=%0d q=%0d r=%0d id=%0d want 6 2 1 0",
                            at - acc, bus.rsp_q, bus.rsp_r, bus.rsp_id);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int acc, at;
      bit ok;
      bus.rsp_ready = 1'b1;
      send(1, 4'd14, 4'd3, acc, ok);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.req_x = {4'd6, 4'd9};
      bus.req_y = {4'd2, 4'd4};
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if ({bus.busy, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_outputs: got busy=%0d valid=%0d ready=%b want 0 0 00",
                            bus.busy, bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++; $display("FAIL rstmid_tie: got %b want 01", bus.req_ready);
      end
      acc = cyc;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(at, ok);
      checks++;
      if (!ok || (at - acc !== TW + 2) ||
          ({bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz} !== {4'd2, 4'd1, 1'b0, 1'b0})) begin
         errors++; $display("FAIL rstmid_result: got lat=%0d q=%0d r=%0d id=%0d dbz=%0d want 6 2 1 0 0",
                            at - acc, bus.rsp_q, bus.rsp_r, bus.rsp_id, bus.rsp_dbz);
      end
      @(negedge clk);
   endtask

   initial begin
      clk           = 1'b0;
      rst_n         = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_x     = {4'd3, 4'd5};
      bus.req_y     = {4'd1, 4'd2};
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_dbz();
      test_alternate();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
